muldiv_sequencer: RTL and testbench

Controller between the EX stage and the shared iterative 32x32 unsigned multiply engine. Owns the architectural HI/LO registers. Accepts MULTU/MFHI/MFLO/MTHI/MTLO from EX, launches the engine, and waits for completion. Stalls the pipeline while a multiply is in flight and flags an engine timeout.

---
 rtl/muldiv_sequencer_if.sv | 33 +++
 rtl/muldiv_sequencer.sv | 122 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// EX-stage / multiply-engine signal bundle for muldiv_sequencer.
// master = EX stage plus engine side, slave = the sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic               op_valid;
    logic [2:0]         op;
    logic               flush;
    logic [WIDTH-1:0]   rs_val;
    logic [WIDTH-1:0]   rt_val;
    logic               stall;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;
    logic               eng_start;
    logic [WIDTH-1:0]   eng_a;
    logic [WIDTH-1:0]   eng_b;
    logic               eng_done;
    logic [2*WIDTH-1:0] eng_prod;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;
    logic               err;

    modport master (
        output op_valid, op, flush, rs_val, rt_val, eng_done, eng_prod,
        input  stall, rd_data, rd_valid, eng_start, eng_a, eng_b, hi, lo, busy, err
    );

    modport slave (
        input  op_valid, op, flush, rs_val, rt_val, eng_done, eng_prod,
        output stall, rd_data, rd_valid, eng_start, eng_a, eng_b, hi, lo, busy, err
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// HI/LO owner and launch/wait controller for the shared iterative multiply engine.
// Stalls EX while a MULTU is in flight and abandons the engine after TIMEOUT WAIT cycles.
module muldiv_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 40
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b001,
        OP_MFHI  = 3'b010,
        OP_MFLO  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             eng_start, busy, err;
    logic [WIDTH-1:0] eng_a, eng_b, hi, lo;
    logic             live, is_mul, accept, commit, tmo;
    logic             stall, rd_valid;
    logic [WIDTH-1:0] rd_data;

    always_comb begin
        live     = bus.op_valid & ~bus.flush;
        is_mul   = (bus.op >= OP_MULTU) && (bus.op <= OP_MTLO);
        state_n  = state;
        accept   = 1'b0;
        commit   = 1'b0;
        tmo      = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        stall    = live & is_mul & (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (live && bus.op == OP_MULTU) begin
                    accept  = 1'b1;
                    state_n = S_START;
                end
                if (live && bus.op == OP_MFHI) begin
                    rd_valid = 1'b1;
                    rd_data  = hi;
                end
                if (live && bus.op == OP_MFLO) begin
                    rd_valid = 1'b1;
                    rd_data  = lo;
                end
            end
            S_START: state_n = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done) begin
                    commit  = 1'b1;
                    state_n = S_IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            eng_start <= 1'b0;
            eng_a     <= '0;
            eng_b     <= '0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            busy      <= (state_n != S_IDLE);
            eng_start <= accept;
            err       <= tmo;
            if (accept) begin
                eng_a <= bus.rs_val;
                eng_b <= bus.rt_val;
            end
            if (state == S_START)
                cnt <= '0;
            else if (state == S_WAIT && !bus.eng_done)
                cnt <= cnt + CW'(1);
            // Engine result wins over timeout; MTHI/MTLO only reach here from IDLE.
            if (commit) begin
                hi <= bus.eng_prod[2*WIDTH-1:WIDTH];
                lo <= bus.eng_prod[WIDTH-1:0];
            end else if (tmo) begin
                hi <= '0;
                lo <= '0;
            end else if (state == S_IDLE && live) begin
                if (bus.op == OP_MTHI) hi <= bus.rs_val;
                if (bus.op == OP_MTLO) lo <= bus.rs_val;
            end
        end
    end

    assign bus.stall     = stall;
    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = rd_valid;
    assign bus.eng_start = eng_start;
    assign bus.eng_a     = eng_a;
    assign bus.eng_b     = eng_b;
    assign bus.hi        = hi;
    assign bus.lo        = lo;
    assign bus.busy      = busy;
    assign bus.err       = err;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: the engine side is played by hand with fixed done timing.
module tb_muldiv_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .TIMEOUT(40)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.op_valid = 1'b0;
        bus.op       = 3'b000;
        bus.flush    = 1'b0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.eng_done = 1'b0;
        bus.eng_prod = '0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic fl);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.flush    = fl;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.eng_start !== 1'b0) begin failures++; $display("FAIL reset_eng_start got=%0h exp=0", bus.eng_start); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.err); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%0h/%0h exp=0/0", bus.hi, bus.lo); end
        checks++; if (bus.eng_a !== 32'h0 || bus.eng_b !== 32'h0) begin failures++; $display("FAIL reset_eng_ab got=%0h/%0h exp=0/0", bus.eng_a, bus.eng_b); end
        checks++; if (bus.stall !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin failures++; $display("FAIL reset_comb got=%0h/%0h/%0h exp=0/0/0", bus.stall, bus.rd_valid, bus.rd_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_multu_basic;
        int starts;
        issue(3'b001, 32'd3, 32'd5, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        checks++; if (bus.eng_start !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("FAIL basic_launch got=%0h/%0h exp=1/1", bus.eng_start, bus.busy); end
        checks++; if (bus.eng_a !== 32'd3 || bus.eng_b !== 32'd5) begin failures++; $display("FAIL basic_operands got=%0h/%0h exp=3/5", bus.eng_a, bus.eng_b); end
        starts = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (bus.eng_start) starts++;
        end
        checks++; if (starts !== 0) begin failures++; $display("FAIL basic_start_pulse extra=%0d exp=0", starts); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_wait got=%0h exp=1", bus.busy); end
        bus.eng_done = 1'b1;
        bus.eng_prod = 64'd15;
        tick();
        bus.eng_done = 1'b0;
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin failures++; $display("FAIL basic_hilo got=%0h/%0h exp=0/f", bus.hi, bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_drop got=%0h exp=0", bus.busy); end
    endtask

    task automatic test_stall_mfhi;
        int stall_low;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        issue(3'b010, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b1 || bus.rd_valid !== 1'b0) begin failures++; $display("FAIL mfhi_stall_start got=%0h/%0h exp=1/0", bus.stall, bus.rd_valid); end
        stall_low = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.stall !== 1'b1) stall_low++;
        end
        checks++; if (stall_low !== 0) begin failures++; $display("FAIL mfhi_stall_wait low_cycles=%0d exp=0", stall_low); end
        bus.eng_done = 1'b1;
        bus.eng_prod = 64'hFFFF_FFFE_0000_0001;
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mfhi_stall_done got=%0h exp=1", bus.stall); end
        tick();
        bus.eng_done = 1'b0;
        checks++; if (bus.stall !== 1'b0 || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL mfhi_release got=%0h/%0h exp=0/1", bus.stall, bus.rd_valid); end
        checks++; if (bus.rd_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mfhi_data got=%0h exp=fffffffe", bus.rd_data); end
        checks++; if (bus.lo !== 32'h1) begin failures++; $display("FAIL mfhi_lo got=%0h exp=1", bus.lo); end
        bus.op_valid = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin failures++; $display("FAIL mfhi_novalid got=%0h/%0h exp=0/0", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_mthi_mfhi;
        issue(3'b100, 32'h1234_5678, 32'h0, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%0h exp=0", bus.stall); end
        tick();
        issue(3'b010, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.rd_data !== 32'h1234_5678 || bus.rd_valid !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL mthi_mfhi got=%0h/%0h/%0h exp=12345678/1/0", bus.rd_data, bus.rd_valid, bus.stall); end
        bus.op = 3'b011;
        #1;
        checks++; if (bus.rd_data !== 32'h1 || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL mflo_data got=%0h/%0h exp=1/1", bus.rd_data, bus.rd_valid); end
        tick();
        bus.op_valid = 1'b0;
    endtask

    task automatic test_mtlo_flush;
        issue(3'b101, 32'hDEAD_BEEF, 32'h0, 1'b1);
        tick();
        checks++; if (bus.lo !== 32'h1) begin failures++; $display("FAIL mtlo_flush_lo got=%0h exp=1", bus.lo); end
        bus.op = 3'b010;
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL mfhi_flush_valid got=%0h exp=0", bus.rd_valid); end
        issue(3'b001, 32'd9, 32'd9, 1'b1);
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.eng_start !== 1'b0) begin failures++; $display("FAIL multu_flush_idle got=%0h/%0h exp=0/0", bus.busy, bus.eng_start); end
        idle_inputs();
    endtask

    task automatic test_flush_inflight;
        issue(3'b001, 32'h0001_0000, 32'h0001_0000, 1'b0);
        tick();
        issue(3'b001, 32'h0, 32'h0, 1'b1);
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_inflight_stall got=%0h exp=0", bus.stall); end
        repeat (4) tick();
        bus.eng_done = 1'b1;
        bus.eng_prod = 64'h0000_0001_0000_0000;
        tick();
        idle_inputs();
        checks++; if (bus.hi !== 32'h1 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin failures++; $display("FAIL flush_inflight_hilo got=%0h/%0h/%0h exp=1/0/0", bus.hi, bus.lo, bus.busy); end
    endtask

    task automatic test_back_to_back;
        issue(3'b001, 32'd6, 32'd7, 1'b0);
        tick();
        issue(3'b001, 32'd8, 32'd9, 1'b0);
        tick();
        checks++; if (bus.stall !== 1'b1 || bus.eng_a !== 32'd6 || bus.eng_b !== 32'd7) begin failures++; $display("FAIL b2b_hold got=%0h/%0h/%0h exp=1/6/7", bus.stall, bus.eng_a, bus.eng_b); end
        bus.op = 3'b110;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL b2b_nonmul_stall got=%0h exp=0", bus.stall); end
        bus.op = 3'b001;
        repeat (2) tick();
        bus.eng_done = 1'b1;
        bus.eng_prod = 64'd42;
        tick();
        bus.eng_done = 1'b0;
        checks++; if (bus.lo !== 32'd42 || bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.eng_start !== 1'b0) begin failures++; $display("FAIL b2b_first got=%0h/%0h/%0h/%0h exp=2a/0/0/0", bus.lo, bus.busy, bus.stall, bus.eng_start); end
        tick();
        bus.op_valid = 1'b0;
        checks++; if (bus.eng_start !== 1'b1 || bus.eng_a !== 32'd8 || bus.eng_b !== 32'd9) begin failures++; $display("FAIL b2b_second_start got=%0h/%0h/%0h exp=1/8/9", bus.eng_start, bus.eng_a, bus.eng_b); end
        repeat (3) tick();
        bus.eng_done = 1'b1;
        bus.eng_prod = 64'd72;
        tick();
        idle_inputs();
        checks++; if (bus.lo !== 32'd72 || bus.hi !== 32'h0) begin failures++; $display("FAIL b2b_second_hilo got=%0h/%0h exp=0/48", bus.hi, bus.lo); end
    endtask

    task automatic test_timeout;
        int   n;
        logic seen;
        logic busy_prev;
        issue(3'b001, 32'd7, 32'd9, 1'b0);
        tick();
        idle_inputs();
        n = 0;
        seen = 1'b0;
        busy_prev = 1'b0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (bus.err === 1'b1) seen = 1'b1;
            else busy_prev = bus.busy;
        end
        checks++; if (n !== 41) begin failures++; $display("FAIL timeout_cycles got=%0d exp=41", n); end
        checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || busy_prev !== 1'b1) begin failures++; $display("FAIL timeout_state got=%0h/%0h/%0h/%0h exp=0/0/0/1", bus.busy, bus.hi, bus.lo, busy_prev); end
        tick();
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%0h exp=0", bus.err); end
        bus.eng_done = 1'b1;
        bus.eng_prod = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        bus.eng_done = 1'b0;
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin failures++; $display("FAIL timeout_spurious got=%0h/%0h exp=0/0", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_midwait;
        issue(3'b001, 32'd2, 32'd3, 1'b0);
        tick();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.eng_start !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_start got=%0h/%0h exp=0/0", bus.eng_start, bus.busy); end
        reset = 1'b0;
        tick();
        issue(3'b100, 32'hAAAA_5555, 32'h0, 1'b0);
        tick();
        issue(3'b101, 32'h5555_AAAA, 32'h0, 1'b0);
        tick();
        issue(3'b001, 32'd4, 32'd5, 1'b0);
        tick();
        idle_inputs();
        repeat (3) tick();
        checks++; if (bus.hi !== 32'hAAAA_5555 || bus.lo !== 32'h5555_AAAA || bus.busy !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0h/%0h/%0h exp=aaaa5555/5555aaaa/1", bus.hi, bus.lo, bus.busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_async got=%0h/%0h/%0h exp=0/0/0", bus.hi, bus.lo, bus.busy); end
        reset = 1'b0;
        tick();
        bus.eng_done = 1'b1;
        bus.eng_prod = 64'd20;
        tick();
        bus.eng_done = 1'b0;
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_late_done got=%0h/%0h/%0h exp=0/0/0", bus.hi, bus.lo, bus.busy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle_inputs();
        test_reset();
        test_multu_basic();
        test_stall_mfhi();
        test_mthi_mfhi();
        test_mtlo_flush();
        test_flush_inflight();
        test_back_to_back();
        test_timeout();
        test_reset_midwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
